// File: rtl/uart_rx_sequencer_if.sv
// Serial receive bus between the RX front end and the byte consumer.
// The sequencer takes the slave side; the tick source / line driver takes the master side.
interface uart_rx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 rx_done;
    logic                 frame_error;

    modport master (
        output tick,
        output rx,
        input  data,
        input  rx_done,
        input  frame_error
    );

    modport slave (
        input  tick,
        input  rx,
        output data,
        output rx_done,
        output frame_error
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start/data/stop sampling driven by a shared
// baud tick, producing a registered byte plus one-cycle done / framing-error strobes.
module uart_rx_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int DIVISION  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_rx_sequencer_if.slave    bus
);
    localparam int S_W = ($clog2(DIVISION) > 4) ? $clog2(DIVISION) : 4;
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [S_W-1:0] S_ZERO = {S_W{1'b0}};
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [S_W-1:0] S_MID  = S_W'(DIVISION / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(DIVISION - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_ZERO = {N_W{1'b0}};
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic [1:0]           sync_r;
    logic                 rx_s;
    logic                 tick_s;
    logic [1:0]           state_r, state_s;
    logic [S_W-1:0]       s_r, s_s;
    logic [N_W-1:0]       n_r, n_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 rx_done_r, rx_done_s;
    logic                 frame_error_r, frame_error_s;

    assign rx_s   = sync_r[1];
    assign tick_s = bus.tick;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.rx};
        end
    end

    // Next-state logic: every counter moves only on a tick, except the IDLE start detect.
    always_comb begin
        state_s       = state_r;
        s_s           = s_r;
        n_s           = n_r;
        shift_s       = shift_r;
        data_s        = data_r;
        rx_done_s     = 1'b0;
        frame_error_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_s = START;
                    s_s     = S_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (s_r == S_MID) begin
                        s_s = S_ZERO;
                        // A line that is high again at mid-start was a glitch.
                        if (!rx_s) begin
                            state_s = DATA;
                            n_s     = N_ZERO;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (s_r == S_BIT) begin
                        s_s     = S_ZERO;
                        shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (n_r == N_LAST) begin
                            state_s = STOP;
                        end else begin
                            n_s = n_r + N_ONE;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (s_r == S_STOP) begin
                        state_s = IDLE;
                        s_s     = S_ZERO;
                        if (rx_s) begin
                            data_s    = shift_r;
                            rx_done_s = 1'b1;
                        end else begin
                            frame_error_s = 1'b1;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            default: begin
                state_s = IDLE;
                s_s     = S_ZERO;
                n_s     = N_ZERO;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            s_r           <= S_ZERO;
            n_r           <= N_ZERO;
            shift_r       <= {DATA_BITS{1'b0}};
            data_r        <= {DATA_BITS{1'b0}};
            rx_done_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            s_r           <= s_s;
            n_r           <= n_s;
            shift_r       <= shift_s;
            data_r        <= data_s;
            rx_done_r     <= rx_done_s;
            frame_error_r <= frame_error_s;
        end
    end

    assign bus.data        = data_r;
    assign bus.rx_done     = rx_done_r;
    assign bus.frame_error = frame_error_r;
endmodule
